// File: rtl/context_switch_unit.sv
// Context save/restore sequencer: copies registers 1..31 to a data-memory save area and back.
// Build option CTX_SKIP_KERNEL_EN skips registers 26/27 (interrupt-captured PC) in both directions.
//
// state      | meaning
// IDLE       | ports released, waiting for save_req / restore_req
// SAVE       | one register read and one memory write per cycle
// RESTORE    | memory read one cycle ahead of the register-file write
// DONE       | one-cycle completion pulse, ports still held
`timescale 1ns/1ps
module context_switch_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int SAVE_BASE  = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  save_req,
  input  logic                  restore_req,
  output logic                  busy,
  output logic                  done,
  output logic [4:0]            rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic [4:0]            rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

`ifdef CTX_SKIP_KERNEL_EN
  localparam bit SKIP_KERNEL = 1'b1;
`else
  localparam bit SKIP_KERNEL = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_SAVE, ST_RESTORE, ST_DONE} state_t;

  state_t                  state_q, state_d;
  logic [4:0]              idx_q, idx_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [4:0]              rf_raddr_q, rf_raddr_d;
  logic [4:0]              rf_waddr_q, rf_waddr_d;
  logic                    rf_we_q, rf_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic                    mem_we_q, mem_we_d;

  // 31 wraps to 0, which marks "nothing left to fetch" during restore.
  function automatic logic [4:0] next_idx(input logic [4:0] idx);
    if (SKIP_KERNEL && idx == 5'd25) return 5'd28;
    return idx + 5'd1;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] slot_addr(input logic [4:0] idx);
    return ADDR_WIDTH'(SAVE_BASE) + ADDR_WIDTH'(idx) - ADDR_WIDTH'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    rf_raddr_d = '0;
    rf_waddr_d = '0;
    rf_we_d    = 1'b0;
    mem_addr_d = '0;
    mem_we_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (save_req) begin
          state_d = ST_SAVE;
          idx_d   = 5'd1;
        end else if (restore_req) begin
          state_d = ST_RESTORE;
          idx_d   = 5'd1;
        end
      end
      ST_SAVE: begin
        if (idx_q == 5'd31) state_d = ST_DONE;
        else                idx_d   = next_idx(idx_q);
      end
      ST_RESTORE: begin
        // The write lags the fetch by one cycle; the prime cycle has rf_we_q low.
        if (rf_we_q && rf_waddr_q == 5'd31) begin
          state_d = ST_DONE;
        end else begin
          rf_we_d    = 1'b1;
          rf_waddr_d = idx_q;
          idx_d      = next_idx(idx_q);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase

    // Outputs for the coming cycle are decoded from the next state.
    case (state_d)
      ST_SAVE: begin
        busy_d     = 1'b1;
        mem_we_d   = 1'b1;
        rf_raddr_d = idx_d;
        mem_addr_d = slot_addr(idx_d);
      end
      ST_RESTORE: begin
        busy_d = 1'b1;
        if (idx_d != 5'd0) mem_addr_d = slot_addr(idx_d);
      end
      ST_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rf_raddr_q <= '0;
      rf_waddr_q <= '0;
      rf_we_q    <= 1'b0;
      mem_addr_q <= '0;
      mem_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rf_raddr_q <= rf_raddr_d;
      rf_waddr_q <= rf_waddr_d;
      rf_we_q    <= rf_we_d;
      mem_addr_q <= mem_addr_d;
      mem_we_q   <= mem_we_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rf_raddr  = rf_raddr_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_we     = rf_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = (state_q == ST_SAVE) ? rf_rdata : '0;
  assign rf_wdata  = rf_we_q ? mem_rdata : '0;

endmodule

// File: tb/tb_context_switch_unit.sv
// Directed bench for context_switch_unit: register-file and memory models, per-scenario tasks.
`timescale 1ns/1ps
module tb_context_switch_unit;
  localparam int DW = 32;
  localparam int AW = 10;
`ifdef CTX_SKIP_KERNEL_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  localparam int SAVE_DONE = SKIP ? 30 : 32;
  localparam int REST_DONE = SKIP ? 31 : 33;
  localparam int NREGS     = SKIP ? 29 : 31;
  localparam logic [DW-1:0] MARK = 32'hDEAD_0000;

  logic clock = 1'b0, reset = 1'b1, save_req = 1'b0, restore_req = 1'b0;
  logic busy, done, rf_we, mem_we;
  logic [4:0] rf_raddr, rf_waddr;
  logic [DW-1:0] rf_rdata, rf_wdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] rf_arr [32];
  logic [DW-1:0] rf_init [32];
  logic [DW-1:0] mem_arr [1024];
  logic [DW-1:0] mem_init [1024];
  logic rf_load = 1'b0, mem_load = 1'b0;

  logic save_req_w = 1'b0;
  logic busy_w, done_w, rf_we_w, mem_we_w;
  logic [4:0] rf_raddr_w, rf_waddr_w;
  logic [DW-1:0] rf_rdata_w, rf_wdata_w, mem_wdata_w;
  logic [AW-1:0] mem_addr_w;
  logic [DW-1:0] mem_w [1024];

  int errors = 0, checks = 0;
  int busy_cnt, done_cnt, done_cyc, mem_we_cnt, rf_we_cnt, first_rf_we, post_rst_or;

  always #5 clock = ~clock;

  context_switch_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SAVE_BASE(64)) dut (
    .clock(clock), .reset(reset), .save_req(save_req), .restore_req(restore_req),
    .busy(busy), .done(done), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_we(rf_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata));

  context_switch_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SAVE_BASE(1020)) dut_w (
    .clock(clock), .reset(reset), .save_req(save_req_w), .restore_req(1'b0),
    .busy(busy_w), .done(done_w), .rf_raddr(rf_raddr_w), .rf_rdata(rf_rdata_w),
    .rf_waddr(rf_waddr_w), .rf_wdata(rf_wdata_w), .rf_we(rf_we_w),
    .mem_addr(mem_addr_w), .mem_wdata(mem_wdata_w), .mem_we(mem_we_w), .mem_rdata('0));

  assign rf_rdata   = rf_arr[rf_raddr];
  assign rf_rdata_w = 32'h7700_0000 | {27'd0, rf_raddr_w};

  always @(posedge clock) begin
    if (mem_load) for (int i = 0; i < 1024; i++) mem_arr[i] <= mem_init[i];
    else if (mem_we) mem_arr[mem_addr] <= mem_wdata;
    mem_rdata <= mem_arr[mem_addr];
  end

  // The register file writes on the falling edge.
  always @(negedge clock) begin
    if (rf_load) for (int i = 0; i < 32; i++) rf_arr[i] <= rf_init[i];
    else if (rf_we) rf_arr[rf_waddr] <= rf_wdata;
  end

  always @(posedge clock) if (mem_we_w) mem_w[mem_addr_w] <= mem_wdata_w;

  function automatic bit skipped(input int k);
    return SKIP && (k == 26 || k == 27);
  endfunction

  function automatic bit outs_nonzero();
    return busy || done || rf_we || mem_we || (rf_raddr != 0) || (rf_waddr != 0) ||
           (mem_addr != 0) || (mem_wdata != 0) || (rf_wdata != 0);
  endfunction

  task automatic load(input bit do_rf, input bit do_mem);
    rf_load = do_rf; mem_load = do_mem;
    @(posedge clock); #1;
    rf_load = 1'b0; mem_load = 1'b0;
  endtask

  task automatic fill(input logic [DW-1:0] rf_base);
    for (int i = 0; i < 32; i++) rf_init[i] = (i == 0) ? '0 : rf_base + i;
    for (int i = 0; i < 1024; i++) mem_init[i] = MARK;
  endtask

  task automatic pulse_req(input bit s, input bit r);
    save_req = s; restore_req = r;
    @(posedge clock); #1;
    save_req = 1'b0; restore_req = 1'b0;
  endtask

  // Iteration cyc observes cycle cyc after the request edge.
  task automatic run_window(input int ncyc, input int rr_cyc, input int rst_cyc);
    busy_cnt = 0; done_cnt = 0; done_cyc = 0; mem_we_cnt = 0; rf_we_cnt = 0;
    first_rf_we = 0; post_rst_or = 0;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      restore_req = (cyc == rr_cyc);
      reset = (cyc == rst_cyc);
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (mem_we) mem_we_cnt++;
      if (rf_we) begin rf_we_cnt++; if (first_rf_we == 0) first_rf_we = cyc; end
      if (rst_cyc > 0 && cyc == rst_cyc + 1) post_rst_or = outs_nonzero() ? 1 : 0;
      @(posedge clock); #1;
    end
    restore_req = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (outs_nonzero()) begin errors++; $display("FAIL reset_outputs: some output nonzero busy=%0b done=%0b mem_addr=%0d, expected all 0", busy, done, mem_addr); end
    reset = 1'b0;
    @(posedge clock); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_save;
    fill(32'hA000_0000); load(1, 1);
    pulse_req(1, 0); run_window(36, 0, 0);
    checks++; if (busy_cnt !== SAVE_DONE) begin errors++; $display("FAIL save_busy_cycles: got %0d expected %0d", busy_cnt, SAVE_DONE); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL save_done_count: got %0d expected 1", done_cnt); end
    checks++; if (done_cyc !== SAVE_DONE) begin errors++; $display("FAIL save_done_cycle: got %0d expected %0d", done_cyc, SAVE_DONE); end
    checks++; if (mem_we_cnt !== NREGS) begin errors++; $display("FAIL save_mem_we_count: got %0d expected %0d", mem_we_cnt, NREGS); end
    checks++; if (rf_we_cnt !== 0) begin errors++; $display("FAIL save_rf_we_count: got %0d expected 0", rf_we_cnt); end
    for (int k = 1; k < 32; k++) begin
      logic [DW-1:0] exp;
      exp = skipped(k) ? MARK : 32'hA000_0000 + k;
      checks++; if (mem_arr[63+k] !== exp) begin errors++; $display("FAIL save_slot_%0d: got %h expected %h", k, mem_arr[63+k], exp); end
    end
    checks++; if (mem_arr[63] !== MARK || mem_arr[95] !== MARK) begin errors++; $display("FAIL save_outside_area: got %h/%h expected %h", mem_arr[63], mem_arr[95], MARK); end
    checks++; if (outs_nonzero()) begin errors++; $display("FAIL save_idle_after: outputs nonzero busy=%0b mem_addr=%0d expected 0", busy, mem_addr); end
  endtask

  task automatic test_restore;
    for (int i = 0; i < 32; i++) rf_init[i] = '0;
    for (int i = 0; i < 1024; i++) mem_init[i] = MARK;
    for (int k = 1; k < 32; k++) mem_init[63+k] = 32'h5500_0000 + k;
    load(1, 1);
    pulse_req(0, 1); run_window(38, 0, 0);
    checks++; if (done_cyc !== REST_DONE) begin errors++; $display("FAIL restore_done_cycle: got %0d expected %0d", done_cyc, REST_DONE); end
    checks++; if (busy_cnt !== REST_DONE) begin errors++; $display("FAIL restore_busy_cycles: got %0d expected %0d", busy_cnt, REST_DONE); end
    checks++; if (rf_we_cnt !== NREGS) begin errors++; $display("FAIL restore_rf_we_count: got %0d expected %0d", rf_we_cnt, NREGS); end
    checks++; if (first_rf_we !== 2) begin errors++; $display("FAIL restore_first_write: got cycle %0d expected 2", first_rf_we); end
    checks++; if (mem_we_cnt !== 0) begin errors++; $display("FAIL restore_mem_we_count: got %0d expected 0", mem_we_cnt); end
    checks++; if (rf_arr[0] !== '0) begin errors++; $display("FAIL restore_reg0: got %h expected 0", rf_arr[0]); end
    for (int k = 1; k < 32; k++) begin
      logic [DW-1:0] exp;
      exp = skipped(k) ? '0 : 32'h5500_0000 + k;
      checks++; if (rf_arr[k] !== exp) begin errors++; $display("FAIL restore_reg_%0d: got %h expected %h", k, rf_arr[k], exp); end
    end
  endtask

  task automatic test_simultaneous;
    fill(32'hB000_0000); load(1, 1);
    pulse_req(1, 1); run_window(40, 10, 0);
    checks++; if (rf_we_cnt !== 0) begin errors++; $display("FAIL simul_rf_we_count: got %0d expected 0", rf_we_cnt); end
    checks++; if (done_cnt !== 1 || done_cyc !== SAVE_DONE) begin errors++; $display("FAIL simul_done: got %0d pulses at %0d expected 1 at %0d", done_cnt, done_cyc, SAVE_DONE); end
    checks++; if (mem_we_cnt !== NREGS) begin errors++; $display("FAIL simul_mem_we_count: got %0d expected %0d", mem_we_cnt, NREGS); end
    checks++; if (mem_arr[64] !== 32'hB000_0001) begin errors++; $display("FAIL simul_slot_1: got %h expected b0000001", mem_arr[64]); end
    checks++; if (mem_arr[94] !== 32'hB000_001F) begin errors++; $display("FAIL simul_slot_31: got %h expected b000001f", mem_arr[94]); end
  endtask

  task automatic test_back_to_back;
    int rr;
    rr = SAVE_DONE + 1;
    fill(32'hD000_0000); load(1, 1);
    pulse_req(1, 0); run_window(rr + 36, rr, 0);
    checks++; if (done_cnt !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt); end
    checks++; if (done_cyc !== rr + REST_DONE) begin errors++; $display("FAIL b2b_restore_done: got %0d expected %0d", done_cyc, rr + REST_DONE); end
    checks++; if (first_rf_we !== rr + 2) begin errors++; $display("FAIL b2b_first_write: got %0d expected %0d", first_rf_we, rr + 2); end
    checks++; if (rf_arr[31] !== 32'hD000_001F) begin errors++; $display("FAIL b2b_reg31: got %h expected d000001f", rf_arr[31]); end
  endtask

  task automatic test_reset_mid_save;
    fill(32'hC000_0000); load(1, 1);
    pulse_req(1, 0); run_window(40, 0, 11);
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL midrst_done_count: got %0d expected 0", done_cnt); end
    checks++; if (mem_we_cnt !== 11) begin errors++; $display("FAIL midrst_mem_we_count: got %0d expected 11", mem_we_cnt); end
    checks++; if (busy_cnt !== 11) begin errors++; $display("FAIL midrst_busy_cycles: got %0d expected 11", busy_cnt); end
    checks++; if (post_rst_or !== 0) begin errors++; $display("FAIL midrst_outputs: got nonzero=%0d expected 0", post_rst_or); end
    for (int k = 1; k < 32; k++) begin
      logic [DW-1:0] exp;
      exp = (k <= 11) ? 32'hC000_0000 + k : MARK;
      checks++; if (mem_arr[63+k] !== exp) begin errors++; $display("FAIL midrst_slot_%0d: got %h expected %h", k, mem_arr[63+k], exp); end
    end
  endtask

  task automatic test_wrap;
    int dcnt, rf_act;
    dcnt = 0; rf_act = 0;
    save_req_w = 1'b1; @(posedge clock); #1; save_req_w = 1'b0;
    for (int cyc = 1; cyc <= 36; cyc++) begin
      if (done_w) dcnt++;
      if (rf_we_w || rf_waddr_w != 0 || rf_wdata_w != 0 || (busy_w && 1'b0)) rf_act++;
      @(posedge clock); #1;
    end
    checks++; if (mem_w[0] !== 32'h7700_0005) begin errors++; $display("FAIL wrap_reg5_addr0: got %h expected 77000005", mem_w[0]); end
    checks++; if (mem_w[26] !== 32'h7700_001F) begin errors++; $display("FAIL wrap_reg31_addr26: got %h expected 7700001f", mem_w[26]); end
    checks++; if (mem_w[1020] !== 32'h7700_0001) begin errors++; $display("FAIL wrap_reg1_addr1020: got %h expected 77000001", mem_w[1020]); end
    checks++; if (mem_w[1023] !== 32'h7700_0004) begin errors++; $display("FAIL wrap_reg4_addr1023: got %h expected 77000004", mem_w[1023]); end
    checks++; if (dcnt !== 1 || rf_act !== 0) begin errors++; $display("FAIL wrap_control: got done=%0d rf_activity=%0d expected 1/0", dcnt, rf_act); end
  endtask

  task automatic test_round_trip;
    fill(32'hE000_0000); load(1, 1);
    pulse_req(1, 0); run_window(36, 0, 0);
    for (int i = 0; i < 32; i++) rf_init[i] = '0;
    rf_init[26] = 32'h0000_0040;
    load(1, 0);
    pulse_req(0, 1); run_window(38, 0, 0);
    checks++; if (rf_arr[26] !== (SKIP ? 32'h0000_0040 : 32'hE000_001A)) begin errors++; $display("FAIL trip_reg26: got %h expected %h", rf_arr[26], SKIP ? 32'h0000_0040 : 32'hE000_001A); end
    checks++; if (rf_arr[27] !== (SKIP ? 32'h0 : 32'hE000_001B)) begin errors++; $display("FAIL trip_reg27: got %h expected %h", rf_arr[27], SKIP ? 32'h0 : 32'hE000_001B); end
    checks++; if (rf_arr[25] !== 32'hE000_0019) begin errors++; $display("FAIL trip_reg25: got %h expected e0000019", rf_arr[25]); end
    checks++; if (rf_arr[28] !== 32'hE000_001C) begin errors++; $display("FAIL trip_reg28: got %h expected e000001c", rf_arr[28]); end
    checks++; if (done_cyc !== REST_DONE) begin errors++; $display("FAIL trip_done_cycle: got %0d expected %0d", done_cyc, REST_DONE); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_save;
    test_restore;
    test_simultaneous;
    test_back_to_back;
    test_reset_mid_save;
    test_wrap;
    test_round_trip;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
